// File: rtl/cic_decim_ctrl.sv
// Burst controller wrapped around a CIC decimator: clears the filter,
// drops its warm-up outputs, then forwards a fixed number of samples.
module cic_decim_ctrl #(
    parameter int WIDTH        = 65,
    parameter int COUNT_WIDTH  = 16,
    parameter int DISCARD      = 5,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [COUNT_WIDTH-1:0] i_length,
    input  logic [WIDTH-1:0]       i_inph_data,
    input  logic [WIDTH-1:0]       i_quad_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [WIDTH-1:0]       o_cic_inph,
    output logic [WIDTH-1:0]       o_cic_quad,
    output logic                   o_cic_valid,
    output logic                   o_cic_reset,
    input  logic [WIDTH-1:0]       i_cic_inph,
    input  logic [WIDTH-1:0]       i_cic_quad,
    input  logic                   i_cic_valid,
    output logic [WIDTH-1:0]       o_inph_data,
    output logic [WIDTH-1:0]       o_quad_data,
    output logic                   o_valid,
    output logic                   o_last,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [COUNT_WIDTH-1:0] o_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WARMUP,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] DISC_LAST =
        COUNT_WIDTH'(DISCARD > 0 ? DISCARD - 1 : 0);
    localparam logic [COUNT_WIDTH-1:0] CLR_LAST =
        COUNT_WIDTH'(CLEAR_CYCLES > 1 ? CLEAR_CYCLES - 1 : 0);

    state_t                 state_q;
    state_t                 state_d;
    logic [COUNT_WIDTH-1:0] len_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] disc_q;
    logic [COUNT_WIDTH-1:0] clr_q;
    logic [COUNT_WIDTH-1:0] count_inc;
    logic                   start_ok;
    logic                   clr_end;
    logic                   disc_end;
    logic                   fwd;
    logic                   hit_len;
    logic                   accept;

    assign start_ok  = (state_q == S_IDLE) && i_start && !i_abort;
    assign clr_end   = (clr_q == CLR_LAST);
    assign disc_end  = i_cic_valid && (disc_q == DISC_LAST);
    assign fwd       = (state_q == S_RUN) && i_cic_valid && !i_abort;
    assign count_inc = count_q + 1'b1;
    assign hit_len   = fwd && (count_inc == len_q);
    assign accept    = i_valid && o_ready;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (clr_end) begin
                    if (len_q == '0)       state_d = S_DONE;
                    else if (DISCARD == 0) state_d = S_RUN;
                    else                   state_d = S_WARMUP;
                end
            end
            S_WARMUP: begin
                if (disc_end) state_d = S_RUN;
            end
            S_RUN: begin
                if (hit_len) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_abort) state_d = S_IDLE;
    end

    // Ready drops combinationally on the final sample and on abort.
    always_comb begin
        o_busy  = (state_q == S_CLEAR) || (state_q == S_WARMUP)
               || (state_q == S_RUN);
        o_ready = ((state_q == S_WARMUP)
               || ((state_q == S_RUN) && !hit_len)) && !i_abort;
        o_done  = (state_q == S_DONE) && !i_abort;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            len_q   <= '0;
            count_q <= '0;
            disc_q  <= '0;
            clr_q   <= '0;
        end else begin
            clr_q <= (state_q == S_CLEAR) ? clr_q + 1'b1 : '0;
            if (start_ok) begin
                len_q   <= i_length;
                count_q <= '0;
                disc_q  <= '0;
            end else begin
                if ((state_q == S_WARMUP) && i_cic_valid)
                    disc_q <= disc_q + 1'b1;
                if (fwd && (count_q != len_q))
                    count_q <= count_inc;
            end
        end
    end

    // Clear is registered so it deasserts on the first edge after reset.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_cic_reset <= 1'b1;
            o_cic_valid <= 1'b0;
            o_cic_inph  <= '0;
            o_cic_quad  <= '0;
            o_valid     <= 1'b0;
            o_last      <= 1'b0;
            o_inph_data <= '0;
            o_quad_data <= '0;
        end else begin
            o_cic_reset <= (state_d == S_CLEAR);
            o_cic_valid <= accept;
            if (accept) begin
                o_cic_inph <= i_inph_data;
                o_cic_quad <= i_quad_data;
            end
            o_valid <= fwd;
            o_last  <= hit_len;
            if (fwd) begin
                o_inph_data <= i_cic_inph;
                o_quad_data <= i_cic_quad;
            end
        end
    end

    assign o_count = count_q;

endmodule
